// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered ripple adder.
// The producer uses the master modport; the adder itself uses slave.
interface full_adder_if #(
  parameter int WIDTH = 1
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             out_valid;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    input  sum,
    input  cout,
    input  overflow,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    output sum,
    output cout,
    output overflow,
    output out_valid
  );

endinterface

// File: rtl/full_adder.sv
// Ripple-carry adder for the ALU add/sub core: sum = a + b + cin,
// with unsigned carry-out and signed overflow. The chain is built from
// one explicit cell per bit so each carry is a distinct, probeable net.
// REGISTER_OUT selects a one-cycle registered result or a purely
// combinational path.

// Single-bit full adder cell.
module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

module full_adder #(
  parameter int WIDTH        = 1,
  parameter bit REGISTER_OUT = 1'b1
) (
  input logic         clk,
  input logic         rst,
  full_adder_if.slave bus
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_overflow;

  assign w_carry[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .i_a (bus.a[i]),
      .i_b (bus.b[i]),
      .i_c (w_carry[i]),
      .o_s (w_sum[i]),
      .o_c (w_carry[i+1])
    );
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  // For WIDTH=1 the carry into the MSB is cin itself.
  assign w_cout     = w_carry[WIDTH];
  assign w_overflow = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  if (REGISTER_OUT) begin : g_reg
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_overflow;
    logic             r_out_valid;

    // Capture qualified results; hold the last result while idle, and
    // let reset clear everything including any in-flight result.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sum       <= '0;
        r_cout      <= 1'b0;
        r_overflow  <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_sum      <= w_sum;
          r_cout     <= w_cout;
          r_overflow <= w_overflow;
        end
      end
    end

    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_overflow;
    assign bus.out_valid = r_out_valid;
  end else begin : g_comb
    // Zero-latency path: clk is not used, rst only gates out_valid.
    assign bus.sum       = w_sum;
    assign bus.cout      = w_cout;
    assign bus.overflow  = w_overflow;
    assign bus.out_valid = bus.in_valid & ~rst;
  end

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: a 1-bit and an 8-bit registered
// instance checked through expected-result queues, plus a 4-bit
// combinational instance checked directly.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst;
  logic rst_c;

  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(8)) bus8 ();
  full_adder_if #(.WIDTH(4)) bus4 ();

  full_adder #(.WIDTH(1), .REGISTER_OUT(1'b1)) u_w1 (.clk(clk), .rst(rst),   .bus(bus1));
  full_adder #(.WIDTH(8), .REGISTER_OUT(1'b1)) u_w8 (.clk(clk), .rst(rst),   .bus(bus8));
  full_adder #(.WIDTH(4), .REGISTER_OUT(1'b0)) u_c4 (.clk(clk), .rst(rst_c), .bus(bus4));

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a registered instance presents a result.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus1.out_valid === 1'b1) begin
        if (q1.size() == 0) check("w1_unexpected_valid", 8'd1, 8'd0);
        else begin
          exp_t e;
          e = q1.pop_front();
          check("w1_sum",  {7'b0, bus1.sum},      e.sum);
          check("w1_cout", {7'b0, bus1.cout},     {7'b0, e.cout});
          check("w1_ovf",  {7'b0, bus1.overflow}, {7'b0, e.ovf});
        end
      end
      if (bus8.out_valid === 1'b1) begin
        if (q8.size() == 0) check("w8_unexpected_valid", 8'd1, 8'd0);
        else begin
          exp_t e;
          e = q8.pop_front();
          check("w8_sum",  bus8.sum,              e.sum);
          check("w8_cout", {7'b0, bus8.cout},     {7'b0, e.cout});
          check("w8_ovf",  {7'b0, bus8.overflow}, {7'b0, e.ovf});
        end
      end
    end
  end

  task automatic drive1(input logic a, input logic b, input logic c,
                        input logic s, input logic co, input logic ov);
    exp_t e;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b1;
    bus1.a = a; bus1.b = b; bus1.cin = c;
    e.sum = {7'b0, s}; e.cout = co; e.ovf = ov;
    q1.push_back(e);
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] s, input logic co, input logic ov);
    exp_t e;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b1;
    bus8.a = a; bus8.b = b; bus8.cin = c;
    e.sum = s; e.cout = co; e.ovf = ov;
    q8.push_back(e);
  endtask

  task automatic idle_all();
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
  endtask

  // Bounded wait for every queued result to be seen.
  task automatic drain(input string name);
    int k = 0;
    while ((q1.size() != 0 || q8.size() != 0) && k < 20) begin
      @(negedge clk);
      k++;
    end
    #1;
    check(name, 8'(q1.size() + q8.size()), 8'd0);
  endtask

  // Hand-computed (sum, cout, overflow) for (a,b,cin) = 000..111.
  localparam logic [7:0] W1_SUM  = 8'b1001_0110;
  localparam logic [7:0] W1_COUT = 8'b1110_1000;
  localparam logic [7:0] W1_OVF  = 8'b0100_0010;

  initial begin
    logic [7:0] t_sum;
    logic [7:0] t_cout;
    logic [7:0] t_ovf;
    t_sum = W1_SUM; t_cout = W1_COUT; t_ovf = W1_OVF;

    rst = 1'b1; rst_c = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_w1_valid", {7'b0, bus1.out_valid}, 8'd0);
    check("rst_w1_sum",   {7'b0, bus1.sum},       8'd0);
    check("rst_w8_valid", {7'b0, bus8.out_valid}, 8'd0);
    check("rst_w8_sum",   bus8.sum,               8'd0);
    check("rst_w8_cout",  {7'b0, bus8.cout},      8'd0);

    // All eight 1-bit combinations back to back.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      drive1(v[2], v[1], v[0], t_sum[i], t_cout[i], t_ovf[i]);
    end
    idle_all();
    @(negedge clk);
    // 1+1+1 result must be held while idle, with out_valid low.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("w1_hold_sum",   {7'b0, bus1.sum},       8'd1);
      check("w1_hold_cout",  {7'b0, bus1.cout},      8'd1);
      check("w1_hold_valid", {7'b0, bus1.out_valid}, 8'd0);
    end
    drain("w1_drain");

    // 8-bit boundary vectors, back to back.
    drive8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    drive8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    drive8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
    drive8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    idle_all();
    drain("w8_drain");

    // Reset on the same edge as a qualified input discards it.
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus8.in_valid = 1'b1; bus8.a = 8'h05; bus8.b = 8'h03; bus8.cin = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    check("midrst_sum",   bus8.sum,               8'd0);
    check("midrst_cout",  {7'b0, bus8.cout},      8'd0);
    check("midrst_ovf",   {7'b0, bus8.overflow},  8'd0);
    check("midrst_valid", {7'b0, bus8.out_valid}, 8'd0);
    drive8(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    idle_all();
    drain("postrst_drain");

    // Combinational 4-bit instance, no clock edge involved.
    @(negedge clk);
    #2;
    bus4.a = 4'hF; bus4.b = 4'h0; bus4.cin = 1'b1; bus4.in_valid = 1'b1;
    #1;
    check("c4_sum",   {4'b0, bus4.sum},       8'h00);
    check("c4_cout",  {7'b0, bus4.cout},      8'd1);
    check("c4_ovf",   {7'b0, bus4.overflow},  8'd0);
    check("c4_valid", {7'b0, bus4.out_valid}, 8'd1);
    bus4.in_valid = 1'b0;
    #1;
    check("c4_valid_low", {7'b0, bus4.out_valid}, 8'd0);
    bus4.in_valid = 1'b1; rst_c = 1'b1;
    #1;
    check("c4_valid_rst", {7'b0, bus4.out_valid}, 8'd0);
    rst_c = 1'b0;
    bus4.a = 4'h7; bus4.b = 4'h1; bus4.cin = 1'b0;
    #1;
    check("c4_sum_7p1",  {4'b0, bus4.sum},      8'h08);
    check("c4_cout_7p1", {7'b0, bus4.cout},     8'd0);
    check("c4_ovf_7p1",  {7'b0, bus4.overflow}, 8'd1);
    bus4.a = 4'h8; bus4.b = 4'h8; bus4.cin = 1'b0;
    #1;
    check("c4_sum_8p8",  {4'b0, bus4.sum},      8'h00);
    check("c4_cout_8p8", {7'b0, bus4.cout},     8'd1);
    check("c4_ovf_8p8",  {7'b0, bus4.overflow}, 8'd1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
Registered binary adder for the RISC-V ALU datapath. Computes sum = a + b + cin and produces a carry-out and a signed-overflow flag. Built internally as a ripple chain of 1-bit full-adder cells. The default WIDTH=1 gives the classic single-bit full adder, and wider instances serve as the ALU add/sub core.

Parameters:
- WIDTH, default 1: operand and sum width in bits (legal values ≥1).
- REGISTER_OUT, default 1: 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational, and clk/rst are ignored except for out_valid.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a, b, cin this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).
- out_valid  output  1  sum/cout/overflow hold a result for a qualified input.

Behaviour:
- Bit cell i: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i]); c[0] = cin.
- cout = c[WIDTH]; overflow = c[WIDTH] ^ c[WIDTH-1].
- For WIDTH=1, c[0] = cin, so overflow = cout ^ cin.
- Ripple chain must be generated structurally per bit, not with a single "+" operator, so every cell stays individually observable in simulation.
- REGISTER_OUT=1:
  - On a rising clk edge with rst=1: sum=0, cout=0, overflow=0, out_valid=0. rst has priority over in_valid.
  - On a rising clk edge with rst=0 and in_valid=1: register the new sum/cout/overflow; out_valid=1 on the next cycle.
  - On a rising clk edge with rst=0 and in_valid=0: sum/cout/overflow hold their previous values; out_valid=0.
  - Latency is exactly 1 cycle. Throughput is one result per cycle, with back-to-back inputs allowed.
  - rst asserted mid-stream discards the in-flight result: outputs are 0 the cycle after the rst edge.
  - Outputs before the first reset edge are unspecified. The bench must reset first.
- REGISTER_OUT=0:
  - sum/cout/overflow follow the inputs combinationally with zero latency.
  - out_valid = in_valid & ~rst (combinational).
- Arithmetic is unsigned modulo 2^WIDTH. Wrap-around is reported only via cout (unsigned) and overflow (signed). No saturation.
- No X-propagation masking: X on an input bit may propagate to the dependent sum bits and carries.

Test Plan:
- WIDTH=1, REGISTER_OUT=1: assert rst for 2 cycles, then drive all 8 (a,b,cin) combos 000..111 with in_valid=1, one per cycle. Required one cycle later (sum,cout) = 00,10,10,01,10,01,01,11 and out_valid=1.
- WIDTH=1, REGISTER_OUT=1: a=1, b=1, cin=1 with in_valid=1, then in_valid=0 for 3 cycles. Required: sum=1, cout=1 held throughout; out_valid high for 1 cycle only.
- WIDTH=8: a=0xFF, b=0x01, cin=0. Required: sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01, cin=0. Required: sum=0x80, cout=0, overflow=1.
- WIDTH=8: a=0x80, b=0x80, cin=1. Required: sum=0x01, cout=1, overflow=1. Then a=0x12, b=0x34, cin=1. Required: sum=0x47, cout=0, overflow=0.
- Reset mid-operation: in_valid=1 with a=0x05, b=0x03 and rst=1 on the same edge. Required next cycle: sum=0, cout=0, overflow=0, out_valid=0. First valid input after rst deasserts produces a correct result 1 cycle later.
- REGISTER_OUT=0, WIDTH=4: a=0xF, b=0x0, cin=1. Required, same delta cycle with no clock: sum=0x0, cout=1, overflow=0, out_valid=in_valid.
